// File: rtl/waveform_capture_if.sv
// Pixel byte stream from the capture buffer to the plotter command path.
interface waveform_capture_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/waveform_capture.sv
// 8-channel triggered capture into a DEPTH-sample record, replayed as packed
// 8-sample pixel bytes of one channel (oldest sample in bit 7).
module waveform_capture #(
  parameter int DEPTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         sample_in,
  input  logic [PRESC_W-1:0] presc,
  input  logic [2:0]         trig_ch,
  input  logic [1:0]         trig_mode,
  input  logic               start,
  input  logic               abort,
  input  logic               rd_start,
  input  logic [2:0]         rd_ch,
  waveform_capture_if.master px,
  output logic [2:0]         status
);

  localparam int NB = DEPTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DONE    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] cnt, presc_l;
  logic [2:0]         trig_ch_l, rd_ch_l;
  logic [1:0]         trig_mode_l;
  logic               prev, first;
  logic [AW-1:0]      wr_ptr;
  logic [KW-1:0]      k;
  logic               ov, ol;
  logic [7:0]         od;
  logic [DEPTH-1:0][7:0] mem;

  logic          tick, cur, trig_hit, wr_en;
  logic [AW-1:0] wr_idx, rd_base;
  logic [KW-1:0] k_nx, byte_sel;
  logic [2:0]    ch_sel;
  logic [7:0]    rd_byte;

  assign status       = state;
  assign px.out_valid = ov;
  assign px.out_data  = od;
  assign px.out_last  = ol;

  assign tick = (state == S_ARMED || state == S_CAPTURE) && (cnt == '0);
  assign cur  = sample_in[trig_ch_l];

  // The first tick after arming only seeds prev, so edge modes cannot fire on it.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_l)
      2'b00: trig_hit = 1'b1;
      2'b01: trig_hit = !first && !prev &&  cur;
      2'b10: trig_hit = !first &&  prev && !cur;
      2'b11: trig_hit = !first && (prev != cur);
      default: trig_hit = 1'b0;
    endcase
  end

  assign wr_en  = rst_n && !abort && tick &&
                  ((state == S_ARMED && trig_hit) || state == S_CAPTURE);
  assign wr_idx = (state == S_ARMED) ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= sample_in;
  end

  // Byte being loaded into the output register: byte 0 of rd_ch on rd_start,
  // otherwise the byte after the one currently presented.
  assign k_nx = k + KW'(1);
  always_comb begin
    byte_sel = (state == S_READOUT) ? k_nx : '0;
    ch_sel   = (state == S_READOUT) ? rd_ch_l : rd_ch;
    rd_base  = AW'({byte_sel, 3'b000});
    rd_byte  = '0;
    for (int j = 0; j < 8; j++) rd_byte[7-j] = mem[rd_base + AW'(j)][ch_sel];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      presc_l     <= '0;
      trig_ch_l   <= '0;
      trig_mode_l <= '0;
      rd_ch_l     <= '0;
      prev        <= 1'b0;
      first       <= 1'b0;
      wr_ptr      <= '0;
      k           <= '0;
      ov          <= 1'b0;
      od          <= '0;
      ol          <= 1'b0;
    end else if (abort) begin
      state  <= S_IDLE;
      ov     <= 1'b0;
      ol     <= 1'b0;
      wr_ptr <= '0;
    end else begin
      if (state == S_ARMED || state == S_CAPTURE)
        cnt <= tick ? presc_l : cnt - PRESC_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_ARMED;
            presc_l     <= presc;
            cnt         <= presc;
            trig_ch_l   <= trig_ch;
            trig_mode_l <= trig_mode;
            first       <= 1'b1;
            wr_ptr      <= '0;
          end
        end
        S_ARMED: begin
          if (tick) begin
            prev  <= cur;
            first <= 1'b0;
            if (trig_hit) begin
              wr_ptr <= AW'(1);
              state  <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (tick) begin
            if (wr_ptr == AW'(DEPTH - 1)) begin
              wr_ptr <= '0;
              state  <= S_DONE;
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state       <= S_ARMED;
            presc_l     <= presc;
            cnt         <= presc;
            trig_ch_l   <= trig_ch;
            trig_mode_l <= trig_mode;
            first       <= 1'b1;
            wr_ptr      <= '0;
          end else if (rd_start) begin
            state   <= S_READOUT;
            rd_ch_l <= rd_ch;
            k       <= '0;
            ov      <= 1'b1;
            od      <= rd_byte;
            ol      <= (NB == 1);
          end
        end
        S_READOUT: begin
          if (ov && px.out_ready) begin
            if (ol) begin
              state <= S_DONE;
              ov    <= 1'b0;
              ol    <= 1'b0;
            end else begin
              k  <= k_nx;
              od <= rd_byte;
              ol <= (k_nx == KW'(NB - 1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
